inst_mem_resp: RTL and testbench
================================

# inst_mem_resp

Instruction-memory responder for the fetch side of `rvcpu`: it answers the core's `inst_addr`/`inst_ena` fetch requests with a 32-bit `inst`. After reset it clears its storage to NOPs, then accepts a program image over a simple valid/ready load port, then serves fetches with one-cycle registered latency. It replaces the testbench ROM model so the core sees a deterministic, synthesizable instruction source with fault reporting.

## Interface
- `DEPTH_LOG2`, default 12: log2 of memory depth in 32-bit words (4096 words).
- `BASE_ADDR`, default 64'h0000_0000_8000_0000: byte address of word 0.
- `NOP_INST`, default 32'h0000_0013: fill and idle value (`addi x0,x0,0`).

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset (sampled on `clk`; 0 = reset).
- `inst_addr`  in  64  fetch byte address from core.
- `inst_ena`  in  1  fetch request, sampled each cycle.
- `inst`  out  32  fetched instruction (registered).
- `inst_valid`  out  1  `inst` corresponds to a fetch accepted last cycle.
- `inst_fault`  out  1  accepted fetch was misaligned or out of range.
- `ld_valid`  in  1  loader write request.
- `ld_ready`  out  1  loader write accepted this cycle when `ld_valid & ld_ready`.
- `ld_addr`  in  64  loader byte address.
- `ld_data`  in  32  loader word.
- `ld_last`  in  1  qualifies final loader beat.
- `ld_err`  out  1  sticky: a loader beat was out of range or misaligned.
- `boot_done`  out  1  high while in RUN.

## Operation
- FSM states: CLEAR, LOAD, RUN. Reset → CLEAR.
- CLEAR: index counter `clr_idx` (DEPTH_LOG2 bits) starts at 0; each cycle writes `NOP_INST` to `mem[clr_idx]`, increments. When `clr_idx == 2^DEPTH_LOG2-1` is written → LOAD next cycle. `ld_ready=0`, fetches ignored.
- LOAD: `ld_ready=1` (combinational from state). On beat (`ld_valid & ld_ready`): offset = `ld_addr - BASE_ADDR` (64-bit unsigned wrap); if `offset[1:0]==0` and `offset[63:2] < 2^DEPTH_LOG2`, write `mem[offset[DEPTH_LOG2+1:2]] = ld_data`; else drop write, set `ld_err`. If beat has `ld_last` → RUN next cycle (regardless of error). Fetches ignored.
- RUN: `ld_ready=0`; loader beats ignored. When `inst_ena=1`: same offset rule on `inst_addr`; in range and aligned → next cycle `inst=mem[idx]`, `inst_valid=1`, `inst_fault=0`; else `inst=NOP_INST`, `inst_valid=1`, `inst_fault=1`. When `inst_ena=0`: next cycle `inst_valid=0`, `inst_fault=0`, `inst` holds previous value.
- RUN is terminal until reset.
- Memory: single write port (CLEAR or LOAD writer, mutually exclusive by state), one synchronous read port.

## Timing
- Reset values: `inst=NOP_INST`, `inst_valid=0`, `inst_fault=0`, `ld_ready=0`, `ld_err=0`, `boot_done=0`, `clr_idx=0`.
- CLEAR lasts exactly 2^DEPTH_LOG2 cycles after reset deassertion; `ld_ready` rises on the following cycle.
- Load beat: zero-latency accept; written data visible to fetches in RUN.
- `ld_last` beat accepted in cycle N → `boot_done=1` and fetch sampling from cycle N+1.
- Fetch latency: request in cycle N → `inst`/`inst_valid`/`inst_fault` valid after edge N+1; back-to-back fetches every cycle, full throughput.
- Reset asserted mid-CLEAR/LOAD/RUN: next edge returns to CLEAR with all outputs at reset values, `ld_err` cleared; memory contents undefined until re-cleared.
- Boundary: last word (`offset = 4·(2^DEPTH_LOG2-1)`) in range; `offset = 4·2^DEPTH_LOG2` faults; `inst_addr < BASE_ADDR` wraps huge → faults.

## Test plan
- DEPTH_LOG2=4: release reset → `ld_ready` rises exactly 16 cycles later; fetch at BASE+0x3C after `ld_last`-only beat returns 32'h00000013, fault=0.
- Load 0x00100093@BASE, 0x00208113@BASE+4 (last) → fetches BASE, BASE+4 on consecutive cycles return those words with `inst_valid=1` one cycle after each.
- Fetch BASE+2 → `inst=32'h13`, `inst_fault=1`; fetch BASE+0x40 (DEPTH 16) → fault=1; fetch BASE-4 → fault=1.
- Loader beat at BASE+0x100 (DEPTH 16) → `ld_err=1`, no memory change; subsequent in-range beat still accepted, `ld_err` stays 1.
- Drop `rst` to 0 one cycle mid-LOAD → `ld_ready=0`, `boot_done=0`, `ld_err=0` next cycle; CLEAR restarts and memory reads NOP after re-boot.
- `inst_ena=0` in RUN after fetch of 0x00100093 → `inst_valid=0`, `inst` still 0x00100093.

Source files
------------

// File: rtl/inst_mem_resp_if.sv
// Fetch and loader bundle between the core/loader side and the instruction memory.
interface inst_mem_resp_if;
    // fetch side
    logic [63:0] inst_addr;
    logic        inst_ena;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_fault;
    // loader side
    logic        ld_valid;
    logic        ld_ready;
    logic [63:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_err;
    logic        boot_done;

    modport master (
        output inst_addr, inst_ena, ld_valid, ld_addr, ld_data, ld_last,
        input  inst, inst_valid, inst_fault, ld_ready, ld_err, boot_done
    );

    modport slave (
        input  inst_addr, inst_ena, ld_valid, ld_addr, ld_data, ld_last,
        output inst, inst_valid, inst_fault, ld_ready, ld_err, boot_done
    );
endinterface

// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: clears storage to NOPs, takes a program image
// over the loader port, then serves fetches with one-cycle registered latency.
module inst_mem_resp #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic clk,
    input  logic rst,               // synchronous, active low
    inst_mem_resp_if.slave bus
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [DEPTH_LOG2-1:0]   clr_idx_reg, clr_idx_next;

    logic [31:0]             mem [DEPTH];

    logic                    wr_en;
    logic [DEPTH_LOG2-1:0]   wr_idx;
    logic [31:0]             wr_data;

    logic [63:0]             ld_off;
    logic                    ld_ok;
    logic [DEPTH_LOG2-1:0]   ld_idx;
    logic                    ld_beat;

    logic [63:0]             f_off;
    logic                    f_ok;
    logic [DEPTH_LOG2-1:0]   f_idx;
    logic                    fetch_acc;

    logic [31:0]             rd_data_reg;
    logic                    nop_sel_reg;
    logic                    inst_valid_reg;
    logic                    inst_fault_reg;
    logic                    ld_err_reg;

    // Address decode: offset from BASE_ADDR wraps, so addresses below the base
    // become huge offsets and fail the range test.
    assign ld_off = bus.ld_addr - BASE_ADDR;
    assign ld_ok  = (ld_off[1:0] == 2'b00) && (ld_off[63:DEPTH_LOG2+2] == '0);
    assign ld_idx = ld_off[DEPTH_LOG2+1:2];

    assign f_off  = bus.inst_addr - BASE_ADDR;
    assign f_ok   = (f_off[1:0] == 2'b00) && (f_off[63:DEPTH_LOG2+2] == '0);
    assign f_idx  = f_off[DEPTH_LOG2+1:2];

    assign ld_beat   = bus.ld_valid && (state_reg == LOAD);
    assign fetch_acc = bus.inst_ena && (state_reg == RUN);

    // State and clear-index registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= CLEAR;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    // Next state plus the single memory write port (CLEAR fill or LOAD beat)
    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        wr_en        = 1'b0;
        wr_idx       = clr_idx_reg;
        wr_data      = NOP_INST;
        case (state_reg)
            CLEAR: begin
                wr_en        = 1'b1;
                clr_idx_next = clr_idx_reg + 1'b1;
                if (clr_idx_reg == LAST_IDX) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (ld_beat) begin
                    wr_en   = ld_ok;
                    wr_idx  = ld_idx;
                    wr_data = bus.ld_data;
                    if (bus.ld_last) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Memory write; suppressed while reset is held
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Registered read, only on an accepted in-range fetch so the value holds otherwise
    always_ff @(posedge clk) begin
        if (fetch_acc && f_ok) begin
            rd_data_reg <= mem[f_idx];
        end
    end

    // Fetch response flags; nop_sel substitutes NOP_INST after reset or a fault
    always_ff @(posedge clk) begin
        if (!rst) begin
            nop_sel_reg    <= 1'b1;
            inst_valid_reg <= 1'b0;
            inst_fault_reg <= 1'b0;
        end else if (fetch_acc) begin
            nop_sel_reg    <= !f_ok;
            inst_valid_reg <= 1'b1;
            inst_fault_reg <= !f_ok;
        end else begin
            inst_valid_reg <= 1'b0;
            inst_fault_reg <= 1'b0;
        end
    end

    // Sticky loader error, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_err_reg <= 1'b0;
        end else if (ld_beat && !ld_ok) begin
            ld_err_reg <= 1'b1;
        end
    end

    assign bus.inst       = nop_sel_reg ? NOP_INST : rd_data_reg;
    assign bus.inst_valid = inst_valid_reg;
    assign bus.inst_fault = inst_fault_reg;
    assign bus.ld_ready   = (state_reg == LOAD);
    assign bus.ld_err     = ld_err_reg;
    assign bus.boot_done  = (state_reg == RUN);

endmodule

// File: tb/tb_inst_mem_resp.sv
// Directed plus randomized bench for inst_mem_resp with a word-array reference model.
module tb_inst_mem_resp;
    localparam int          DL2   = 4;
    localparam int          DEPTH = 16;
    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inst_mem_resp_if bus ();

    inst_mem_resp #(
        .DEPTH_LOG2 (DL2),
        .BASE_ADDR  (BASE),
        .NOP_INST   (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_mem [DEPTH];
    logic        model_err;
    logic [31:0] model_inst;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE;
        return (off % 64'd4 == 64'd0) && (off / 64'd4 < 64'(DEPTH));
    endfunction

    function automatic int addr_word(input logic [63:0] a);
        logic [63:0] off;
        off = (a - BASE) / 64'd4;
        return int'(off[31:0]);
    endfunction

    function automatic logic [63:0] rand_addr;
        case ($urandom_range(0, 9))
            0: return BASE + 64'($urandom_range(0, DEPTH - 1)) * 4 + 64'($urandom_range(1, 3));
            1: return BASE - 64'($urandom_range(1, 4)) * 4;
            2: return BASE + 64'($urandom_range(DEPTH, DEPTH + 24)) * 4;
            default: return BASE + 64'($urandom_range(0, DEPTH - 1)) * 4;
        endcase
    endfunction

    // Reset for one cycle, check reset outputs, then time the clear phase.
    task automatic reset_and_boot;
        int n;
        rst = 1'b0;
        tick();
        chk("rst_ld_ready", bus.ld_ready, 1'b0);
        chk("rst_boot_done", bus.boot_done, 1'b0);
        chk("rst_ld_err", bus.ld_err, 1'b0);
        chk("rst_inst_valid", bus.inst_valid, 1'b0);
        chk("rst_inst_fault", bus.inst_fault, 1'b0);
        chk("rst_inst", bus.inst, NOP);
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
        model_err  = 1'b0;
        model_inst = NOP;
        bus.inst_ena  = 1'b1;
        bus.inst_addr = BASE;
        n = 0;
        while (!bus.ld_ready && n < 200) begin
            tick();
            n++;
        end
        chk("clear_len", 64'(n), 64'(DEPTH));
        chk("clear_fetch_ignored", bus.inst_valid, 1'b0);
        bus.inst_ena = 1'b0;
    endtask

    task automatic beat(input logic [63:0] a, input logic [31:0] d, input logic last);
        bit acc;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        bus.ld_last  = last;
        acc = bus.ld_ready;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        if (acc) begin
            if (addr_ok(a)) model_mem[addr_word(a)] = d;
            else            model_err = 1'b1;
        end
        $display("load addr=%h data=%h last=%0d accepted=%0d ld_err=%0d", a, d, last, acc, bus.ld_err);
        chk("ld_err", bus.ld_err, model_err);
    endtask

    task automatic fetch(input logic [63:0] a, input logic ena);
        logic        e_valid, e_fault;
        bus.inst_ena  = ena;
        bus.inst_addr = a;
        tick();
        if (ena) begin
            e_valid    = 1'b1;
            e_fault    = !addr_ok(a);
            model_inst = addr_ok(a) ? model_mem[addr_word(a)] : NOP;
        end else begin
            e_valid = 1'b0;
            e_fault = 1'b0;
        end
        $display("fetch addr=%h ena=%0d inst=%h valid=%0d fault=%0d", a, ena, bus.inst, bus.inst_valid, bus.inst_fault);
        chk("inst_valid", bus.inst_valid, e_valid);
        chk("inst_fault", bus.inst_fault, e_fault);
        chk("inst", bus.inst, model_inst);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.inst_addr = '0;
        bus.inst_ena  = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.ld_last   = 1'b0;
        model_err     = 1'b0;
        model_inst    = NOP;
        for (int i = 0; i < 3; i++) tick();

        // Boot with a single ld_last beat; top word must still read NOP.
        reset_and_boot();
        beat(BASE, NOP, 1'b1);
        chk("boot_done", bus.boot_done, 1'b1);
        chk("run_ld_ready", bus.ld_ready, 1'b0);
        fetch(BASE + 64'h3C, 1'b1);
        fetch(BASE, 1'b0);
        // Loader beats in RUN are ignored: no error, no write.
        beat(BASE + 64'h100, 32'h1234_5678, 1'b0);
        beat(BASE + 64'h8, 32'hDEAD_BEEF, 1'b0);
        fetch(BASE + 64'h8, 1'b1);

        // Error stickiness in LOAD, then reset mid-LOAD.
        reset_and_boot();
        beat(BASE + 64'h100, 32'h1234_5678, 1'b0);
        chk("ld_err_set", bus.ld_err, 1'b1);
        beat(BASE + 64'h8, 32'hAAAA_5555, 1'b0);
        chk("ld_ready_after_err", bus.ld_ready, 1'b1);
        reset_and_boot();
        beat(BASE, 32'h0010_0093, 1'b0);
        beat(BASE + 64'h4, 32'h0020_8113, 1'b1);
        fetch(BASE, 1'b1);
        fetch(BASE + 64'h4, 1'b1);
        fetch(BASE + 64'h8, 1'b1);
        fetch(BASE + 64'h2, 1'b1);
        fetch(BASE + 64'h40, 1'b1);
        fetch(BASE - 64'h4, 1'b1);
        fetch(BASE + 64'h3C, 1'b1);
        fetch(BASE, 1'b1);
        fetch(BASE + 64'h4, 1'b0);
        chk("hold_inst", bus.inst, 32'h0010_0093);

        // Randomized boots and fetch streams against the model.
        for (int r = 0; r < 3; r++) begin
            reset_and_boot();
            for (int b = 0; b < 20; b++) begin
                beat(rand_addr(), $urandom(), b == 19);
            end
            chk("rand_boot_done", bus.boot_done, 1'b1);
            for (int f = 0; f < 60; f++) begin
                fetch(rand_addr(), $urandom_range(0, 3) != 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
